ser2par32: RTL and testbench
============================

# ser2par32

Serial-to-parallel collector that sits directly downstream of the 32-bit universal shift register. It samples the register's serial output one bit per enabled clock and reassembles complete frames into 32-bit words, in either bit order. Finished words are presented on a valid/ready port with a one-word holding buffer, so the frame being collected and the word being delivered overlap. Lost words are flagged with a sticky overflow.

## Interface
- WIDTH, 32, data word width; bit counter is $clog2(WIDTH+1) bits.
- clk  in  1  rising-edge clock.
- reset_L  in  1  asynchronous, active-low reset.
- bit_valid  in  1  qualifies s_in this cycle; driven from the shift register's enb.
- s_in  in  1  serial data bit (shift register serial output).
- sof  in  1  start of frame; meaningful only with bit_valid=1; that bit is frame bit 0.
- dir  in  1  bit order, sampled at sof: 0 = MSB first (left shift), 1 = LSB first (right shift).
- q  out  WIDTH  assembled word (holding register).
- q_valid  out  1  holding register full.
- q_ready  in  1  consumer accepts q this cycle.
- busy  out  1  frame in progress.
- ovf  out  1  sticky overflow.
- clr_ovf  in  1  synchronous clear of ovf.
- par_err  out  1  parity error, valid with q_valid (only when parity is compiled in).

## Operation
- FSM states: IDLE, COLLECT, PARITY (PARITY exists only when parity is compiled in).
- IDLE: bit_valid&sof stores bit 0, latches dir, sets cnt=1, goes to COLLECT. bit_valid without sof is ignored.
- COLLECT: each bit_valid=1 cycle stores one bit.
  - dir=0: acc = {acc[WIDTH-2:0], s_in}.
  - dir=1: acc = {s_in, acc[WIDTH-1:1]}.
  - cnt increments on each stored bit.
- Last data bit (cnt=WIDTH-1): without parity, the word is completed and the FSM returns to IDLE. With parity, the FSM goes to PARITY.
- PARITY: the next valid bit is the even-parity bit. The word completes and the FSM returns to IDLE.
- Word completion: the completed value (acc with the incoming bit merged in) is written to q on the same edge.
  - The write happens if q_valid=0, or if q_valid&q_ready in that cycle.
  - Otherwise the new word is dropped, q is unchanged, and ovf is set.
- Drain: q_valid&q_ready with no simultaneous completion clears q_valid. Completion and drain in the same cycle leave q_valid=1 with the new word.
- sof&bit_valid in COLLECT or PARITY: the partial frame is discarded and collection restarts with this bit as bit 0. ovf is not affected.
- bit_valid=0: all state holds. Gaps of any length are allowed.
- busy=1 in COLLECT and PARITY.
- clr_ovf and a new overflow in the same cycle: ovf stays 1 (set wins).

## Timing
- Reset (async, reset_L=0) gives:
  - state=IDLE, cnt=0, acc=0, q=0, q_valid=0, busy=0, ovf=0, par_err=0.
  - Reset asserted mid-frame discards the frame and any held word.
- Latency: q/q_valid are updated at the edge that samples the last frame bit and are visible immediately after it. No extra pipeline cycle.
- Back-to-back frames: sof may coincide with the cycle after the last bit. Sustained throughput is one word per WIDTH (or WIDTH+1) valid bits.
- q is stable while q_valid=1 and q_ready=0, unless a reset occurs.
- All outputs are registered.

## Configuration
- PARITY_EN defined:
  - Frame is WIDTH+1 bits; the last bit is even parity over the data bits.
  - par_err is registered with the word: 1 if ^data ≠ parity bit.
  - A dropped word does not update par_err.
- PARITY_EN undefined:
  - Frame is WIDTH bits; the PARITY state is absent.
  - par_err is tied to 0.

## Structure
- Shared package ser2par_pkg holds:
  - state enum (IDLE, COLLECT, PARITY);
  - DIR_MSB_FIRST=0 and DIR_LSB_FIRST=1 constants.
- One sub-module, ser2par_hold: the one-word holding register with valid/ready and overflow logic.
- FSM, counter and accumulator live in the top module.

## Test plan
- MSB-first: sof, then the 32 bits of 32'h0000_0001 shifted out MSB first -> q=32'h0000_0001, q_valid=1 right after bit 31, ovf=0.
- LSB-first with gaps: dir=1, 32'hA5A5_0F0F sent with bit_valid low every third cycle -> q=32'hA5A5_0F0F.
- Backpressure: q_ready=0, two frames 32'h1 then 32'h2 -> q=32'h1, ovf=1. Then q_ready=1 for one cycle -> q_valid=0. Then clr_ovf -> ovf=0.
- Completion and drain same cycle: q holds 32'h1, q_ready=1 on the last-bit edge of frame 32'hFFFF_FFFF -> q=32'hFFFF_FFFF, q_valid=1, ovf=0.
- Restart and reset: sof again after 10 bits, then a full frame 32'hDEAD_BEEF -> q=32'hDEAD_BEEF. reset_L=0 mid-frame -> all outputs 0 asynchronously.
- PARITY_EN: frame 32'h0000_0003 with parity bit 1 -> par_err=1. The same frame with parity bit 0 -> par_err=0.

Source files
------------

// File: rtl/ser2par_pkg.sv
// Shared types for the ser2par32 serial-to-parallel collector.
// The PARITY state exists only when PARITY_EN is defined.
package ser2par_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1
`ifdef PARITY_EN
    , PARITY = 2'd2
`endif
  } state_e;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/ser2par32_if.sv
// Word delivery port of ser2par32: holding register contents with valid/ready.
// The master side owns q/q_valid/par_err, the slave side drives q_ready.
interface ser2par32_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             q_ready;
  logic             par_err;

  modport master (output q, output q_valid, output par_err, input q_ready);
  modport slave  (input q, input q_valid, input par_err, output q_ready);
endinterface

// File: rtl/ser2par_hold.sv
// One-word holding buffer for ser2par32: accepts a completed word when empty or
// draining in the same cycle, otherwise drops it and raises sticky overflow.
module ser2par_hold #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_perr,
  input  logic             clr_ovf,
  output logic             ovf,
  ser2par32_if.master      word
);

  logic accept;

  assign accept = wr_en && (!word.q_valid || word.q_ready);

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // blocking assignments would create read-order races between flops.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      word.q       <= '0;
      word.q_valid <= 1'b0;
      word.par_err <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      if (accept) begin
        word.q       <= wr_data;
        word.q_valid <= 1'b1;
        word.par_err <= wr_perr;
      end else if (word.q_valid && word.q_ready) begin
        word.q_valid <= 1'b0;
      end

      // A lost word outranks a simultaneous clear.
      if (wr_en && !accept) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ser2par32.sv
// Serial-to-parallel collector: frames of WIDTH bits (plus an even-parity bit
// when PARITY_EN is defined) are assembled MSB- or LSB-first into 32-bit words.
module ser2par32
  import ser2par_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset_L,
  input  logic        bit_valid,
  input  logic        s_in,
  input  logic        sof,
  input  logic        dir,
  input  logic        clr_ovf,
  output logic        busy,
  output logic        ovf,
  ser2par32_if.master word
);

  localparam int              CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(WIDTH - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic             dir_r;

  logic             start;
  logic             done;
  logic [WIDTH-1:0] merged;
  logic [WIDTH-1:0] start_word;
  logic [WIDTH-1:0] done_word;
  logic             done_perr;

  assign start      = bit_valid && sof;
  assign merged     = (dir_r == DIR_LSB_FIRST) ? {s_in, acc[WIDTH-1:1]}
                                               : {acc[WIDTH-2:0], s_in};
  assign start_word = (dir == DIR_LSB_FIRST) ? {s_in, {(WIDTH-1){1'b0}}}
                                             : {{(WIDTH-1){1'b0}}, s_in};

  // NOTE: every signal gets a default at the top of always_comb so that no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    done      = 1'b0;
    done_word = merged;
    done_perr = 1'b0;
    if (bit_valid && !sof) begin
`ifdef PARITY_EN
      if (state == PARITY) begin
        done      = 1'b1;
        done_word = acc;
        done_perr = (^acc) != s_in;
      end
`else
      if (state == COLLECT && cnt == LAST_DATA) begin
        done = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      dir_r <= DIR_MSB_FIRST;
      busy  <= 1'b0;
    end else if (start) begin
      // sof always restarts, discarding any partial frame.
      state <= COLLECT;
      cnt   <= CNT_W'(1);
      acc   <= start_word;
      dir_r <= dir;
      busy  <= 1'b1;
    end else if (bit_valid) begin
      case (state)
        COLLECT: begin
          acc <= merged;
          if (cnt == LAST_DATA) begin
`ifdef PARITY_EN
            state <= PARITY;
            cnt   <= cnt + CNT_W'(1);
`else
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

  ser2par_hold #(.WIDTH(WIDTH)) u_hold (
    .clk     (clk),
    .reset_L (reset_L),
    .wr_en   (done),
    .wr_data (done_word),
    .wr_perr (done_perr),
    .clr_ovf (clr_ovf),
    .ovf     (ovf),
    .word    (word)
  );

endmodule

// File: tb/tb_ser2par32.sv
// Directed self-checking bench for ser2par32; frames carry the correct even
// parity bit automatically when PARITY_EN is defined.
module tb_ser2par32;
  import ser2par_pkg::*;

  localparam int WIDTH = 32;
`ifdef PARITY_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif

  logic clk = 1'b0;
  logic reset_L;
  logic bit_valid, s_in, sof, dir, clr_ovf;
  logic busy, ovf;
  int   total = 0;
  int   bad   = 0;

  ser2par32_if #(.WIDTH(WIDTH)) word ();

  ser2par32 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .bit_valid (bit_valid),
    .s_in      (s_in),
    .sof       (sof),
    .dir       (dir),
    .clr_ovf   (clr_ovf),
    .busy      (busy),
    .ovf       (ovf),
    .word      (word)
  );

  always #5 clk = ~clk;

  // Frame position i: data bits in the chosen order, position WIDTH is parity.
  function automatic logic frame_bit(input logic [WIDTH-1:0] w, input logic d, input int i);
    if (i >= WIDTH) return ^w;
    return d ? w[i] : w[WIDTH-1-i];
  endfunction

  task automatic tick(input logic v, input logic b, input logic s, input logic clr);
    bit_valid = v; s_in = b; sof = s; clr_ovf = clr;
    @(posedge clk); #1;
    bit_valid = 1'b0; sof = 1'b0; clr_ovf = 1'b0;
  endtask

  // Sends frame positions lo..hi; with gap, bit_valid drops every third cycle
  // while sof is held high to show it is ignored without bit_valid.
  task automatic send_bits(input logic [WIDTH-1:0] w, input logic d, input int lo,
                           input int hi, input bit gap);
    dir = d;
    for (int i = lo; i <= hi; i++) begin
      tick(1'b1, frame_bit(w, d, i), i == 0, 1'b0);
      if (gap && (i % 3 == 1) && i != hi) tick(1'b0, 1'b1, 1'b1, 1'b0);
    end
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w, input logic d);
    send_bits(w, d, 0, FRAME_BITS - 1, 1'b0);
  endtask

  task automatic test_reset;
    reset_L = 1'b0; bit_valid = 1'b0; s_in = 1'b0; sof = 1'b0; dir = 1'b0;
    clr_ovf = 1'b0; word.q_ready = 1'b0;
    #12;
    total++; if (word.q !== 32'h0) begin bad++; $display("FAIL reset_q got=%h exp=%h", word.q, 32'h0); end
    total++; if (word.q_valid !== 1'b0) begin bad++; $display("FAIL reset_q_valid got=%b exp=0", word.q_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    total++; if (word.par_err !== 1'b0) begin bad++; $display("FAIL reset_par_err got=%b exp=0", word.par_err); end
    reset_L = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_msb_first;
    word.q_ready = 1'b1;
    send_bits(32'h0000_0001, DIR_MSB_FIRST, 0, FRAME_BITS - 2, 1'b0);
    total++; if (word.q_valid !== 1'b0) begin bad++; $display("FAIL msb_early_valid got=%b exp=0", word.q_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL msb_busy got=%b exp=1", busy); end
    send_bits(32'h0000_0001, DIR_MSB_FIRST, FRAME_BITS - 1, FRAME_BITS - 1, 1'b0);
    total++; if (word.q !== 32'h0000_0001) begin bad++; $display("FAIL msb_q got=%h exp=%h", word.q, 32'h0000_0001); end
    total++; if (word.q_valid !== 1'b1) begin bad++; $display("FAIL msb_valid got=%b exp=1", word.q_valid); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL msb_ovf got=%b exp=0", ovf); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL msb_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_lsb_gaps;
    word.q_ready = 1'b1;
    send_bits(32'hA5A5_0F0F, DIR_LSB_FIRST, 0, FRAME_BITS - 1, 1'b1);
    total++; if (word.q !== 32'hA5A5_0F0F) begin bad++; $display("FAIL lsb_q got=%h exp=%h", word.q, 32'hA5A5_0F0F); end
    total++; if (word.q_valid !== 1'b1) begin bad++; $display("FAIL lsb_valid got=%b exp=1", word.q_valid); end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (word.q_valid !== 1'b0) begin bad++; $display("FAIL lsb_drain got=%b exp=0", word.q_valid); end
  endtask

  task automatic test_backpressure;
    word.q_ready = 1'b0;
    send_frame(32'h0000_0001, DIR_MSB_FIRST);
    send_frame(32'h0000_0002, DIR_MSB_FIRST);
    total++; if (word.q !== 32'h0000_0001) begin bad++; $display("FAIL bp_q got=%h exp=%h", word.q, 32'h0000_0001); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL bp_ovf got=%b exp=1", ovf); end
    word.q_ready = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    word.q_ready = 1'b0;
    total++; if (word.q_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", word.q_valid); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL bp_ovf_sticky got=%b exp=1", ovf); end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL bp_clr_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_complete_drain;
    word.q_ready = 1'b0;
    send_frame(32'h0000_0001, DIR_MSB_FIRST);
    send_bits(32'hFFFF_FFFF, DIR_MSB_FIRST, 0, FRAME_BITS - 2, 1'b0);
    total++; if (word.q !== 32'h0000_0001) begin bad++; $display("FAIL cd_q_stable got=%h exp=%h", word.q, 32'h0000_0001); end
    word.q_ready = 1'b1;
    send_bits(32'hFFFF_FFFF, DIR_MSB_FIRST, FRAME_BITS - 1, FRAME_BITS - 1, 1'b0);
    total++; if (word.q !== 32'hFFFF_FFFF) begin bad++; $display("FAIL cd_q got=%h exp=%h", word.q, 32'hFFFF_FFFF); end
    total++; if (word.q_valid !== 1'b1) begin bad++; $display("FAIL cd_valid got=%b exp=1", word.q_valid); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL cd_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_restart;
    word.q_ready = 1'b1;
    send_bits(32'h1234_5678, DIR_MSB_FIRST, 0, 9, 1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rs_busy got=%b exp=1", busy); end
    send_frame(32'hDEAD_BEEF, DIR_MSB_FIRST);
    word.q_ready = 1'b0;
    total++; if (word.q !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rs_q got=%h exp=%h", word.q, 32'hDEAD_BEEF); end
    total++; if (word.q_valid !== 1'b1) begin bad++; $display("FAIL rs_valid got=%b exp=1", word.q_valid); end
  endtask

  task automatic test_reset_mid_frame;
    word.q_ready = 1'b0;
    send_frame(32'h0000_0005, DIR_MSB_FIRST);
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL rm_pre_ovf got=%b exp=1", ovf); end
    send_bits(32'hCAFE_F00D, DIR_LSB_FIRST, 0, 4, 1'b0);
    #2 reset_L = 1'b0;
    #1;
    total++; if (word.q !== 32'h0) begin bad++; $display("FAIL rm_q got=%h exp=%h", word.q, 32'h0); end
    total++; if (word.q_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b exp=0", word.q_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", busy); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rm_ovf got=%b exp=0", ovf); end
    total++; if (word.par_err !== 1'b0) begin bad++; $display("FAIL rm_par_err got=%b exp=0", word.par_err); end
    @(negedge clk);
    reset_L = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_ignore;
    word.q_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ig_busy got=%b exp=0", busy); end
    send_frame(32'h8000_0000, DIR_MSB_FIRST);
    total++; if (word.q !== 32'h8000_0000) begin bad++; $display("FAIL ig_q got=%h exp=%h", word.q, 32'h8000_0000); end
    word.q_ready = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

`ifdef PARITY_EN
  task automatic test_parity;
    word.q_ready = 1'b1;
    send_bits(32'h0000_0003, DIR_MSB_FIRST, 0, WIDTH - 1, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (word.q !== 32'h0000_0003) begin bad++; $display("FAIL par_q got=%h exp=%h", word.q, 32'h0000_0003); end
    total++; if (word.par_err !== 1'b1) begin bad++; $display("FAIL par_err_bad got=%b exp=1", word.par_err); end
    send_bits(32'h0000_0003, DIR_MSB_FIRST, 0, WIDTH - 1, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (word.par_err !== 1'b0) begin bad++; $display("FAIL par_err_good got=%b exp=0", word.par_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_gaps();
    test_backpressure();
    test_complete_drain();
    test_restart();
    test_reset_mid_frame();
    test_idle_ignore();
`ifdef PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
